// File: rtl/boreal_envelope_gate.sv
// Burst event detector: hysteresis FSM with minimum-duration filter and refractory
// hold-off, reporting peak/duration through a single-entry valid/ready slot.
module boreal_envelope_gate #(
  parameter int REFRACT = 64,
  parameter int MIN_DUR = 4,
  parameter int DUR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [23:0]      env,
  input  logic [23:0]      th_on,
  input  logic [23:0]      th_off,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [23:0]      evt_peak,
  output logic [DUR_W-1:0] evt_dur,
  output logic             active,
  output logic [7:0]       drop_cnt
);

  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] MIN_DUR_C = DUR_W'(MIN_DUR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_REFR
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [23:0]      peak_q, peak_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [23:0]      evt_peak_q, evt_peak_d;
  logic [DUR_W-1:0] evt_dur_q, evt_dur_d;
  logic             active_q, active_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             emit;

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    peak_d  = peak_q;
    rcnt_d  = rcnt_q;
    emit    = 1'b0;
    if (valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (env >= th_on) begin
            state_d = S_ACTIVE;
            dur_d   = DUR_W'(1);
            peak_d  = env;
          end
        end
        S_ACTIVE: begin
          if (env < th_off) begin
            if (dur_q >= MIN_DUR_C) begin
              emit = 1'b1;
              if (REFRACT == 0) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_REFR;
                rcnt_d  = RW'(REFRACT);
              end
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            dur_d  = (dur_q == DUR_MAX) ? dur_q : dur_q + DUR_W'(1);
            peak_d = (env > peak_q) ? env : peak_q;
          end
        end
        S_REFR: begin
          // env is deliberately ignored here; the sample that ends hold-off is consumed too
          rcnt_d = rcnt_q - RW'(1);
          if (rcnt_q == RW'(1)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_peak_d  = evt_peak_q;
    evt_dur_d   = evt_dur_q;
    drop_cnt_d  = drop_cnt_q;
    active_d    = (state_d == S_ACTIVE);
    if (emit) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_peak_d  = peak_q;
        evt_dur_d   = dur_q;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dur_q       <= '0;
      peak_q      <= '0;
      rcnt_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_peak_q  <= '0;
      evt_dur_q   <= '0;
      active_q    <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      peak_q      <= peak_d;
      rcnt_q      <= rcnt_d;
      evt_valid_q <= evt_valid_d;
      evt_peak_q  <= evt_peak_d;
      evt_dur_q   <= evt_dur_d;
      active_q    <= active_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_peak  = evt_peak_q;
  assign evt_dur   = evt_dur_q;
  assign active    = active_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/boreal_envelope_gate.md
# boreal_envelope_gate

Event detector that consumes the per-sample envelope stream produced by the envelope EMA stage (`valid`/`env`) and turns it into discrete burst events. A hysteresis state machine with a minimum-duration filter and a refractory hold-off decides each event. It reports each event's peak envelope and duration over a single-entry valid/ready output. It sits directly downstream of the envelope detectors and feeds the beat/feature logic.

## Interface

**Parameters**
- `REFRACT`, 64: hold-off length, in accepted input samples, after an emitted event. 0 means no hold-off.
- `MIN_DUR`, 4: minimum burst length in samples for an event to be emitted. Must be ≥1.
- `DUR_W`, 16: width of the duration counter and of `evt_dur`.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: input sample strobe; the FSM advances only on cycles with `valid`=1.
- `env` in 24: unsigned envelope sample.
- `th_on` in 24: unsigned onset threshold. Sampled on every valid cycle.
- `th_off` in 24: unsigned release threshold. Sampled on every valid cycle.
- `evt_valid` out 1: an event is held in the output slot.
- `evt_ready` in 1: downstream accepts the event.
- `evt_peak` out 24: maximum `env` seen during the event.
- `evt_dur` out DUR_W: number of above-release samples in the event. Saturates at all-ones.
- `active` out 1: FSM is in ACTIVE.
- `drop_cnt` out 8: saturating count of events lost because the slot was full.

## Operation

**Reset values.** All outputs reset to 0, the FSM resets to IDLE, and all internal counters reset to 0.

**FSM.** Transitions are evaluated only when `valid`=1; all comparisons are unsigned.
- **IDLE:**
  - If `env >= th_on`: go to ACTIVE with dur=1 and peak=env.
  - Otherwise: stay in IDLE.
- **ACTIVE:**
  - If `env < th_off` (release): the sample is not counted.
    - If dur ≥ MIN_DUR: emit an event with {peak, dur}. Go to REFRACT with rcnt=REFRACT, or go to IDLE if REFRACT=0.
    - If dur < MIN_DUR: go to IDLE with no event and no drop.
  - Otherwise: dur increments, saturating at 2^DUR_W−1, and peak becomes max(peak, env).
- **REFRACT:** each valid sample decrements rcnt. When rcnt becomes 0, go to IDLE. `env` is ignored in this state, so an onset sample arriving while in REFRACT is discarded and not re-examined in IDLE.

**Misconfiguration.** If `th_off > th_on`, behaviour still follows the rules above. An onset sample with `th_on <= env < th_off` enters ACTIVE and releases on the next valid sample, yielding dur=1.

**Output slot.**
- An emit loads {`evt_peak`, `evt_dur`} and sets `evt_valid`.
- `evt_valid` clears on the cycle in which `evt_valid && evt_ready`.
- **Emit while the slot is occupied:**
  - If `evt_ready`=1 in that same cycle: the old event is consumed, the new event is loaded, and `evt_valid` stays 1.
  - If `evt_ready`=0: the new event is discarded, `drop_cnt` increments (saturating at 255), and the held event is unchanged.
- The event fields are stable while `evt_valid`=1 and `evt_ready`=0.

**Reset mid-operation.** Any in-progress burst, the refractory count, a held event and `drop_cnt` are all cleared. No event is emitted.

**Arithmetic.** `dur` and `rcnt` are unsigned. `rcnt` width is clog2(REFRACT+1), minimum 1.

## Timing

- **Registered outputs:** all outputs are registered; nothing is combinational from the inputs.
- **Onset:** a valid onset sample at edge N makes `active`=1 after edge N.
- **Release:** a release sample at edge N makes `active`=0 and `evt_valid`=1 after edge N (1-cycle latency).
- **Refractory length:** REFRACT valid samples after the release sample, the FSM is in IDLE. The next sample after that can trigger onset.
- **Gaps in `valid`:** cycles with `valid`=0 change no FSM state or counter.
- **Output handshake:** it operates every cycle regardless of `valid`.
- **Throughput:** one event per 1+MIN_DUR+REFRACT samples at most. A consumer that keeps `evt_ready`=1 never sees a drop.

## Test plan

- **Basic event.** Setup: th_on=1000, th_off=800, REFRACT=0. Stimulus: env sequence 0, 1200, 1500, 900, 1100, 700 with evt_ready=1. Required: one event with peak=1500, dur=4; `evt_valid` high for exactly 1 cycle after the 700 sample.
- **Short burst filter.** Stimulus: env 1200, 1300, 500 with MIN_DUR=4. Required: no event, `drop_cnt`=0, FSM back in IDLE.
- **Refractory.** Setup: REFRACT=3. Stimulus: a valid event, then env=2000 on the next 3 samples, then 2000 again. Required: the first 3 samples are ignored; `active`=1 after the 4th sample.
- **Backpressure and drop.** Setup: evt_ready=0, REFRACT=0. Stimulus: two qualifying bursts. Required: the first event is held unchanged and `drop_cnt`=1. Then raise evt_ready: the event is accepted and `evt_valid`=0 next cycle.
- **Same-cycle consume and emit.** Stimulus: evt_ready=1 in the same cycle as a release. Required: the new fields are loaded, `evt_valid` stays 1, and `drop_cnt` is unchanged.
- **Reset and saturation.**
  - Assert `rst` mid-ACTIVE: all outputs are 0 next cycle.
  - With DUR_W=4, run a 20-sample burst: `evt_dur`=15.
